jedro_1_ifu_prefetch: RTL

//  Prefetching instruction fetch unit for jedro_1 cores.
//  - Streams sequential fetches to a fixed-latency instruction memory and buffers responses in a FIFO.
//  - Delivers {instr, pc} to the decoder over a valid/ready handshake.
//  - A jump flushes the FIFO and all in-flight reads, then refetches from the jump target.

---
 rtl/jedro_1_ifu_prefetch_pkg.sv | 13 +
 rtl/jedro_1_ifu_prefetch_if.sv | 43 ++++
 rtl/jedro_1_ifu_prefetch_fifo.sv | 54 +++++
 rtl/jedro_1_ifu_prefetch.sv | 130 +++++++++++++
 4 files changed

// File: rtl/jedro_1_ifu_prefetch_pkg.sv
// rtl/jedro_1_ifu_prefetch_pkg.sv - shared types and defaults for the jedro_1 prefetching fetch unit
package jedro_1_defines;

  localparam int XLEN_DEF            = 32;
  localparam int IFU_FIFO_DEPTH_DEF  = 4;
  localparam int IFU_MEM_LATENCY_DEF = 1;

  typedef struct packed {
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc;
  } ifu_entry_t;

endpackage

// File: rtl/jedro_1_ifu_prefetch_if.sv
// rtl/jedro_1_ifu_prefetch_if.sv - jump, imem and decoder signals of the fetch unit
// Misalign outputs exist only when JEDRO_1_IFU_MISALIGN_CHK_EN is defined.
interface jedro_1_ifu_prefetch_if #(
  parameter int XLEN = 32
) ();

  logic            jmp_i;
  logic [XLEN-1:0] jmp_addr_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [XLEN-1:0] imem_rdata_i;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_valid_o;
  logic            instr_ready_i;
`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
  logic            misalign_o;
  logic [XLEN-1:0] misalign_addr_o;

  modport master (
    input  jmp_i, jmp_addr_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o,
    output misalign_o, misalign_addr_o
  );

  modport slave (
    output jmp_i, jmp_addr_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o,
    input  misalign_o, misalign_addr_o
  );
`else
  modport master (
    input  jmp_i, jmp_addr_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o
  );

  modport slave (
    output jmp_i, jmp_addr_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o
  );
`endif

endinterface

// File: rtl/jedro_1_ifu_prefetch_fifo.sv
// rtl/jedro_1_ifu_prefetch_fifo.sv - prefetch FIFO of {instr, pc} entries with flush
module jedro_1_ifu_fifo
  import jedro_1_defines::*;
#(
  parameter  int DEPTH = IFU_FIFO_DEPTH_DEF,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  ifu_entry_t    wdata_i,
  input  logic          pop_i,
  output ifu_entry_t    rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  ifu_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_cnt;

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + 1'b1;
      if (pop_i)  r_rptr <= r_rptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) r_mem[r_wptr] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rptr];
  assign count_o = r_cnt;
  assign empty_o = (r_cnt == '0);

endmodule

// File: rtl/jedro_1_ifu_prefetch.sv
// rtl/jedro_1_ifu_prefetch.sv - prefetching IFU: credit-based issue, latency tracker, jump flush
// Optional misaligned-jump detection under JEDRO_1_IFU_MISALIGN_CHK_EN.
module jedro_1_ifu_prefetch
  import jedro_1_defines::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter int              FIFO_DEPTH  = IFU_FIFO_DEPTH_DEF,
  parameter int              MEM_LATENCY = IFU_MEM_LATENCY_DEF,
  parameter logic [XLEN-1:0] BOOT_ADDR   = '0
) (
  input logic                     clk_i,
  input logic                     rstn_i,
  jedro_1_ifu_prefetch_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(MEM_LATENCY + 1);

  logic [XLEN-1:0]        r_fetch_pc;
  logic [MEM_LATENCY-1:0] r_trk_vld;
  logic [XLEN-1:0]        r_trk_pc [MEM_LATENCY];

  logic                   w_issue;
  logic                   w_halt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic [CW-1:0]          w_fifo_cnt;
  logic [LW-1:0]          w_infl_cnt;
  ifu_entry_t             w_wdata;
  ifu_entry_t             w_rdata;

  always_comb begin
    w_infl_cnt = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      w_infl_cnt = w_infl_cnt + LW'(r_trk_vld[i]);
    end
  end

  // Credits cover both buffered and in-flight reads, so a push always finds room
  assign w_issue = rstn_i && !bus.jmp_i && !w_halt &&
                   ((int'(w_fifo_cnt) + int'(w_infl_cnt)) < FIFO_DEPTH);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_fetch_pc <= BOOT_ADDR;
    end else if (bus.jmp_i) begin
      r_fetch_pc <= {bus.jmp_addr_i[XLEN-1:2], 2'b00};
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_trk_vld <= '0;
    end else if (bus.jmp_i) begin
      r_trk_vld <= '0;
    end else begin
      r_trk_vld[0] <= w_issue;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_trk_vld[i] <= r_trk_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    r_trk_pc[0] <= r_fetch_pc;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      r_trk_pc[i] <= r_trk_pc[i-1];
    end
  end

  assign w_push        = r_trk_vld[MEM_LATENCY-1];
  assign w_wdata.instr = bus.imem_rdata_i;
  assign w_wdata.pc    = r_trk_pc[MEM_LATENCY-1];
  assign w_pop         = !w_empty && bus.instr_ready_i;

  jedro_1_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (bus.jmp_i),
    .push_i  (w_push),
    .wdata_i (w_wdata),
    .pop_i   (w_pop),
    .rdata_o (w_rdata),
    .count_o (w_fifo_cnt),
    .empty_o (w_empty)
  );

  assign bus.imem_req_o    = w_issue;
  assign bus.imem_addr_o   = r_fetch_pc;
  assign bus.instr_valid_o = !w_empty;
  assign bus.instr_o       = w_empty ? '0 : w_rdata.instr;
  assign bus.instr_pc_o    = w_empty ? '0 : w_rdata.pc;

`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
  logic            r_halt;
  logic            r_misalign;
  logic [XLEN-1:0] r_misalign_addr;
  logic            w_jmp_mis;

  assign w_jmp_mis = bus.jmp_i && (bus.jmp_addr_i[1:0] != 2'b00);

  // Issue stays parked after a misaligned jump until software redirects to an aligned target
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_halt          <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_misalign <= w_jmp_mis;
      if (bus.jmp_i) r_halt <= w_jmp_mis;
      if (w_jmp_mis) r_misalign_addr <= bus.jmp_addr_i;
    end
  end

  assign w_halt              = r_halt;
  assign bus.misalign_o      = r_misalign;
  assign bus.misalign_addr_o = r_misalign_addr;
`else
  logic w_unused_lsb;

  assign w_halt       = 1'b0;
  assign w_unused_lsb = ^bus.jmp_addr_i[1:0];
`endif

endmodule
